// File: rtl/nvme_ctrl_pkg.sv
// Shared NVMe controller constants and types for the entry-buffer read path.
package nvme_ctrl_pkg;

  localparam int NVME_ENTRY_W = 771;
  localparam int NVME_SLOTS   = 8;
  localparam int NVME_SLOT_AW = 3;

  typedef logic [NVME_ENTRY_W-1:0] nvme_entry_t;
  typedef logic [NVME_SLOT_AW-1:0] nvme_slot_t;

endpackage

// File: rtl/nvme_entry_skid3.sv
// 3-deep FIFO of {slot, data} holding entries already read out of the entry buffer.
module nvme_entry_skid3 #(
  parameter int DATA_W = nvme_ctrl_pkg::NVME_ENTRY_W,
  parameter int AW     = nvme_ctrl_pkg::NVME_SLOT_AW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [AW-1:0]     push_slot,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [AW-1:0]     head_slot,
  output logic [DATA_W-1:0] head_data
);

  logic [AW+DATA_W-1:0] mem [3];
  logic [1:0]           wp, rp;
  logic                 do_push, do_pop;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd3) || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= inc3(wp);
      if (do_pop)  rp <= inc3(rp);
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; count gates its visibility.
  always_ff @(posedge clock) begin
    if (do_push) mem[wp] <= {push_slot, push_data};
  end

  assign {head_slot, head_data} = mem[rp];

endmodule

// File: rtl/nvme_entry_reader.sv
// Read-side controller for the NVMe entry buffer: in-order streaming on port A,
// slot credit tracking for the writer, and a one-cycle debug lookup on port B.
module nvme_entry_reader
  import nvme_ctrl_pkg::*;
#(
  parameter int DATA_W = NVME_ENTRY_W,
  parameter int DEPTH  = NVME_SLOTS,
  parameter int AW     = NVME_SLOT_AW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_commit,
  output logic [AW-1:0]     wr_tail,
  output logic              full,
  output logic [AW:0]       occupancy,
  output logic              overflow_err,
  output logic [AW-1:0]     rd_addr_a,
  input  logic [DATA_W-1:0] q_a,
  output logic [AW-1:0]     rd_addr_b,
  input  logic [DATA_W-1:0] q_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [AW-1:0]     out_slot,
  input  logic              lookup_req,
  input  logic [AW-1:0]     lookup_slot,
  output logic              lookup_valid,
  output logic [DATA_W-1:0] lookup_data
);

  logic [AW-1:0] tail, rd_ptr, infl_slot;
  logic [AW:0]   uniss;
  logic [1:0]    buf_cnt;
  logic          inflight;
  logic          commit_ok, pop, issue;

  assign full      = (occupancy == (AW+1)'(DEPTH));
  assign commit_ok = wr_commit && !full;
  assign pop       = out_valid && out_ready;
  // Issue looks only at registered state, so out_ready never reaches rd_addr_a timing.
  assign issue     = (uniss != '0) && (({1'b0, buf_cnt} + {2'b00, inflight}) < 3'd3);

  assign wr_tail   = tail;
  assign rd_addr_a = rd_ptr;
  assign rd_addr_b = lookup_slot;
  assign out_valid = (buf_cnt != 2'd0);
  assign lookup_data = q_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tail         <= '0;
      rd_ptr       <= '0;
      infl_slot    <= '0;
      occupancy    <= '0;
      uniss        <= '0;
      inflight     <= 1'b0;
      overflow_err <= 1'b0;
      lookup_valid <= 1'b0;
    end else begin
      if (commit_ok) tail   <= tail + AW'(1);
      if (issue)     rd_ptr <= rd_ptr + AW'(1);
      if (issue)     infl_slot <= rd_ptr;
      inflight     <= issue;
      lookup_valid <= lookup_req;
      if (wr_commit && full) overflow_err <= 1'b1;

      // Credits return on pop, so a buffered slot is never handed back early.
      case ({commit_ok, pop})
        2'b10:   occupancy <= occupancy + (AW+1)'(1);
        2'b01:   occupancy <= occupancy - (AW+1)'(1);
        default: occupancy <= occupancy;
      endcase

      case ({commit_ok, issue})
        2'b10:   uniss <= uniss + (AW+1)'(1);
        2'b01:   uniss <= uniss - (AW+1)'(1);
        default: uniss <= uniss;
      endcase
    end
  end

  nvme_entry_skid3 #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_slot (infl_slot),
    .push_data (q_a),
    .pop       (pop),
    .count     (buf_cnt),
    .head_slot (out_slot),
    .head_data (out_data)
  );

endmodule

// File: tb/tb_nvme_entry_reader.sv
// Scoreboard bench for nvme_entry_reader with a behavioural entry-buffer RAM.
module tb_nvme_entry_reader;
  import nvme_ctrl_pkg::*;

  localparam int W = NVME_ENTRY_W;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         wr_commit = 1'b0;
  logic [2:0]   wr_tail;
  logic         full;
  logic [3:0]   occupancy;
  logic         overflow_err;
  logic [2:0]   rd_addr_a, rd_addr_b;
  logic [W-1:0] q_a, q_b;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [2:0]   out_slot;
  logic         lookup_req = 1'b0;
  logic [2:0]   lookup_slot = '0;
  logic         lookup_valid;
  logic [W-1:0] lookup_data;

  nvme_entry_reader dut (
    .clock(clock), .reset_n(reset_n), .wr_commit(wr_commit), .wr_tail(wr_tail),
    .full(full), .occupancy(occupancy), .overflow_err(overflow_err),
    .rd_addr_a(rd_addr_a), .q_a(q_a), .rd_addr_b(rd_addr_b), .q_b(q_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_slot(out_slot), .lookup_req(lookup_req), .lookup_slot(lookup_slot),
    .lookup_valid(lookup_valid), .lookup_data(lookup_data)
  );

  always #5 clock = ~clock;

  // Entry buffer: two registered read ports.
  logic [W-1:0] ram [8];
  always @(posedge clock) begin
    q_a <= ram[rd_addr_a];
    q_b <= ram[rd_addr_b];
  end

  typedef struct { logic [2:0] slot; logic [W-1:0] data; } exp_t;
  exp_t         exp_q[$];
  logic [W-1:0] lk_q[$];
  int           pop_cyc[$];

  int         n_chk = 0, n_fail = 0, cyc_n = 0;
  int         model_occ = 0;
  logic [2:0] model_tail = '0;
  bit         model_ovf = 0;
  bit         in_reset = 1;
  bit         stalled_prev = 0;
  logic [2:0] st_slot;
  logic [W-1:0] st_data;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [799:0] t;
    for (int i = 0; i < 25; i++) t[i*32 +: 32] = $urandom();
    return t[W-1:0];
  endfunction

  always @(posedge clock) cyc_n <= cyc_n + 1;

  // Monitor: compare state after the last edge, then model the coming edge.
  always @(negedge clock) begin
    if (!in_reset) begin
      check("occupancy", W'(occupancy), W'(model_occ));
      check("full", W'(full), W'(model_occ == 8));
      check("wr_tail", W'(wr_tail), W'(model_tail));
      check("overflow_err", W'(overflow_err), W'(model_ovf));
      if (stalled_prev) begin
        check("stall_valid", W'(out_valid), W'(1));
        check("stall_slot", W'(out_slot), W'(st_slot));
        check("stall_data", out_data, st_data);
      end
      stalled_prev = out_valid && !out_ready;
      st_slot = out_slot;
      st_data = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_pop: slot %0d with nothing expected", out_slot);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_slot", W'(out_slot), W'(e.slot));
          check("out_data", out_data, e.data);
        end
        pop_cyc.push_back(cyc_n);
      end
      if (lookup_valid) begin
        if (lk_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL lookup_spurious: lookup_valid=1 expected 0");
        end else check("lookup_data", lookup_data, lk_q.pop_front());
      end else if (lk_q.size() != 0) begin
        n_chk++; n_fail++;
        $display("FAIL lookup_missing: lookup_valid=0 expected 1");
        void'(lk_q.pop_front());
      end
      // Reference model for the upcoming edge.
      if (wr_commit) begin
        if (model_occ < 8) begin
          exp_q.push_back('{slot: model_tail, data: ram[model_tail]});
          model_tail = model_tail + 3'd1;
          model_occ++;
        end else model_ovf = 1;
      end
      if (out_valid && out_ready) model_occ--;
      if (lookup_req) lk_q.push_back(ram[lookup_slot]);
    end
  end

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  // Drive one commit this cycle; the writer only fills a slot it holds a credit for.
  task automatic set_commit();
    if (model_occ < 8) ram[model_tail] = rand_word();
    wr_commit = 1'b1;
  endtask

  task automatic commit_n(input int n);
    for (int i = 0; i < n; i++) begin set_commit(); cyc(); end
    wr_commit = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    in_reset = 1; reset_n = 1'b0;
    wr_commit = 1'b0; out_ready = 1'b0; lookup_req = 1'b0;
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_lookup_valid", W'(lookup_valid), W'(0));
    check("rst_overflow", W'(overflow_err), W'(0));
    check("rst_full", W'(full), W'(0));
    check("rst_occupancy", W'(occupancy), W'(0));
    check("rst_wr_tail", W'(wr_tail), W'(0));
    check("rst_rd_addr_a", W'(rd_addr_a), W'(0));
    exp_q.delete(); lk_q.delete(); pop_cyc.delete();
    model_occ = 0; model_tail = '0; model_ovf = 0; stalled_prev = 0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1; in_reset = 0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && (model_occ != 0 || exp_q.size() != 0); i++) cyc();
    @(negedge clock);
    check("drain_occupancy", W'(occupancy), W'(0));
    check("drain_out_valid", W'(out_valid), W'(0));
    check("drain_scoreboard", W'(exp_q.size()), W'(0));
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic check_no_bubble(input string nm);
    check({nm, "_count"}, W'(pop_cyc.size()), W'(8));
    for (int k = 1; k < pop_cyc.size() && k < 8; k++)
      check(nm, W'(pop_cyc[k] - pop_cyc[k-1]), W'(1));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = rand_word();
    do_reset();

    // Single entry latency: valid exactly two edges after the commit edge.
    cyc();
    ram[0] = {rand_word() >> 8, 8'hA5};
    wr_commit = 1'b1; out_ready = 1'b1;
    cyc();
    wr_commit = 1'b0;
    @(negedge clock); check("lat_e0", W'(out_valid), W'(0));
    @(negedge clock); check("lat_e1", W'(out_valid), W'(0));
    @(negedge clock); check("lat_e2", W'(out_valid), W'(1));
    check("lat_slot", W'(out_slot), W'(0));
    check("lat_a5", W'(out_data[7:0]), W'(8'hA5));
    repeat (3) cyc();
    check("lat_occ", W'(occupancy), W'(0));

    // Fill to full, then overflow.
    do_reset();
    cyc(); commit_n(8);
    set_commit(); cyc(); wr_commit = 1'b0;
    @(negedge clock);
    check("ovf_full", W'(full), W'(1));
    check("ovf_occ", W'(occupancy), W'(8));
    check("ovf_err", W'(overflow_err), W'(1));
    check("ovf_tail", W'(wr_tail), W'(0));
    drain();

    // Streaming with ready high, twice around the ring, lookup of slot 5 midway.
    do_reset();
    out_ready = 1'b1;
    cyc(); commit_n(8);
    repeat (6) cyc();
    check_no_bubble("bubble_pass1");
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      set_commit();
      lookup_req = (i == 3); lookup_slot = 3'd5;
      cyc();
    end
    wr_commit = 1'b0; lookup_req = 1'b0;
    repeat (6) cyc();
    check_no_bubble("bubble_pass2");
    drain();

    // Toggling ready with a full output buffer.
    do_reset();
    cyc(); commit_n(3);
    repeat (4) cyc();
    for (int i = 0; i < 14; i++) begin
      out_ready = ~out_ready;
      wr_commit = 1'b0;
      if (i % 3 == 0) set_commit();
      cyc();
    end
    wr_commit = 1'b0;
    drain();

    // Commit and pop together while full: commit still dropped.
    do_reset();
    cyc(); commit_n(8);
    repeat (3) cyc();
    set_commit(); out_ready = 1'b1;
    cyc();
    wr_commit = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    check("same8_err", W'(overflow_err), W'(1));
    check("same8_occ", W'(occupancy), W'(7));
    drain();

    // Commit and pop together at occupancy 4.
    do_reset();
    cyc(); commit_n(4);
    repeat (3) cyc();
    set_commit(); out_ready = 1'b1;
    cyc();
    wr_commit = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    check("same4_occ", W'(occupancy), W'(4));
    check("same4_err", W'(overflow_err), W'(0));
    drain();

    // Random traffic with a reset in the middle of the stream.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset();
      wr_commit = 1'b0;
      if (model_occ < 8 ? ($urandom_range(2) != 0) : ($urandom_range(15) == 0)) set_commit();
      out_ready = ($urandom_range(3) != 0);
      lookup_req = ($urandom_range(3) == 0);
      lookup_slot = 3'($urandom_range(7));
      cyc();
    end
    wr_commit = 1'b0; lookup_req = 1'b0;
    drain();
    check("lookup_queue_empty", W'(lk_q.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
